// File: rtl/alu_sched_if.sv
// alu_sched_if: requester-side bus of the ALU scheduler.
//   Two request channels (port 0 = CPU execute, port 1 = debug/test), each
//   with valid/ready, opcode and signed operands A/B, plus per-port response
//   valid/ready and the shared registered response data and flags
//   ({err, sign, carry, zero}).
//   master : requester view (drives requests and response ready)
//   slave  : scheduler view (drives request ready and responses)
interface alu_sched_if #(
  parameter int unsigned WIDTH = 16
);
  logic             req_valid0;
  logic             req_valid1;
  logic             req_ready0;
  logic             req_ready1;
  logic [2:0]       req_op0;
  logic [2:0]       req_op1;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_b1;
  logic             rsp_valid0;
  logic             rsp_valid1;
  logic             rsp_ready0;
  logic             rsp_ready1;
  logic [WIDTH-1:0] rsp_data;
  logic [3:0]       rsp_flags;

  modport master (
    output req_valid0, req_valid1, req_op0, req_op1,
           req_a0, req_a1, req_b0, req_b1, rsp_ready0, rsp_ready1,
    input  req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_data, rsp_flags
  );

  modport slave (
    input  req_valid0, req_valid1, req_op0, req_op1,
           req_a0, req_a1, req_b0, req_b1, rsp_ready0, rsp_ready1,
    output req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_data, rsp_flags
  );
endinterface

// File: rtl/alu_sched.sv
// alu_sched: shares one combinational ALU between two requesters.
//   Accepts one operation at a time, drives the ALU operand/op/enable lines,
//   holds enable for SETTLE_CYCLES, captures result and flags and returns
//   them to the owning port. Divide/modulo by zero and opcodes 5-7 are
//   answered directly with an error response and never reach the ALU.
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   bus (alu_sched_if)     request/response channels of both ports
//   alu_tmp1/alu_tmp2      ALU operands (registered)
//   alu_op, alu_enable     ALU opcode and output enable
//   alu_result, alu_zero/alu_carry/alu_sign  ALU outputs
// Configuration:
//   ALU_SCHED_RR_EN defined  : round-robin arbitration between the ports
//   ALU_SCHED_RR_EN undefined: fixed priority, port 0 wins
module alu_sched #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_sched_if.slave       bus,
  output logic [WIDTH-1:0] alu_tmp1,
  output logic [WIDTH-1:0] alu_tmp2,
  output logic [2:0]       alu_op,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_sign
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] tmp1_q, tmp1_d;
  logic [WIDTH-1:0] tmp2_q, tmp2_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       flags_q, flags_d;

  logic             ptr;
  logic             grant;
  logic             any_valid;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             bad_op;
  logic             rsp_hs;

`ifdef ALU_SCHED_RR_EN
  logic ptr_q, ptr_d;
  assign ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (rsp_hs) ptr_d = ~owner_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end
`else
  assign ptr = 1'b0;
`endif

  // Arbitration: pointer port wins only when both ports request.
  always_comb begin
    any_valid = bus.req_valid0 | bus.req_valid1;
    if (bus.req_valid0 && bus.req_valid1) grant = ptr;
    else                                  grant = bus.req_valid1;
    sel_op = grant ? bus.req_op1 : bus.req_op0;
    sel_a  = grant ? bus.req_a1  : bus.req_a0;
    sel_b  = grant ? bus.req_b1  : bus.req_b0;
    bad_op = (((sel_op == 3'd3) || (sel_op == 3'd4)) && (sel_b == '0)) ||
             (sel_op >= 3'd5);
    rsp_hs = (state_q == RESP) && (owner_q ? bus.rsp_ready1 : bus.rsp_ready0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      tmp1_q  <= '0;
      tmp2_q  <= '0;
      op_q    <= '0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      tmp1_q  <= tmp1_d;
      tmp2_q  <= tmp2_d;
      op_q    <= op_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    tmp1_d  = tmp1_q;
    tmp2_d  = tmp2_q;
    op_d    = op_q;
    data_d  = data_q;
    flags_d = flags_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          owner_d = grant;
          op_d    = sel_op;
          tmp1_d  = sel_a;
          tmp2_d  = sel_b;
          if (bad_op) begin
            state_d = RESP;
            data_d  = '0;
            flags_d = 4'b1001;
          end else begin
            state_d = SETTLE;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          data_d  = alu_result;
          flags_d = {1'b0, alu_sign, alu_carry, alu_zero};
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; ready is gated by reset so nothing looks accepted while in reset.
  always_comb begin
    bus.req_ready0 = 1'b0;
    bus.req_ready1 = 1'b0;
    if (reset_n && (state_q == IDLE) && any_valid) begin
      bus.req_ready0 = ~grant;
      bus.req_ready1 = grant;
    end
    bus.rsp_valid0 = (state_q == RESP) && !owner_q;
    bus.rsp_valid1 = (state_q == RESP) &&  owner_q;
    bus.rsp_data   = data_q;
    bus.rsp_flags  = flags_q;
    alu_tmp1       = tmp1_q;
    alu_tmp2       = tmp2_q;
    alu_op         = op_q;
    alu_enable     = (state_q == SETTLE);
  end

endmodule

// File: tb/tb_alu_sched.sv
module tb_alu_sched;
  localparam int unsigned W  = 16;
  localparam int unsigned SC = 3;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  alu_tmp1, alu_tmp2, alu_result;
  logic [2:0]    alu_op;
  logic          alu_enable, alu_zero, alu_carry, alu_sign;

  int errors = 0;
  int checks = 0;

  alu_sched_if #(.WIDTH(W)) bus ();

  alu_sched #(.WIDTH(W), .SETTLE_CYCLES(SC)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .alu_tmp1   (alu_tmp1),
    .alu_tmp2   (alu_tmp2),
    .alu_op     (alu_op),
    .alu_enable (alu_enable),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .alu_sign   (alu_sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: carry reports signed overflow for add/sub; outputs 0 when disabled.
  logic signed [W-1:0] sa, sb, sr;
  logic                c;
  always_comb begin
    sa = $signed(alu_tmp1);
    sb = $signed(alu_tmp2);
    sr = '0;
    c  = 1'b0;
    case (alu_op)
      3'd0: begin sr = sa + sb; c = (sa[W-1] == sb[W-1]) && (sr[W-1] != sa[W-1]); end
      3'd1: begin sr = sa - sb; c = (sa[W-1] != sb[W-1]) && (sr[W-1] != sa[W-1]); end
      3'd2: sr = sa * sb;
      3'd3: if (sb != 0) sr = sa / sb;
      3'd4: if (sb != 0) sr = sa % sb;
      default: sr = '0;
    endcase
    alu_result = alu_enable ? sr : '0;
    alu_zero   = alu_enable && (sr == 0);
    alu_sign   = alu_enable && sr[W-1];
    alu_carry  = alu_enable && c;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input bit p);
    return p ? bus.req_ready1 : bus.req_ready0;
  endfunction

  function automatic logic rv(input bit p);
    return p ? bus.rsp_valid1 : bus.rsp_valid0;
  endfunction

  task automatic drive(input bit p, input logic v, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    if (p) begin
      bus.req_valid1 = v; bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
    end else begin
      bus.req_valid0 = v; bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
    end
  endtask

  // Present a request and wait for its accept edge; inputs are scrambled afterwards.
  task automatic issue(input bit p, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input string nm);
    int n = 0;
    @(negedge clk);
    drive(p, 1'b1, op, a, b);
    #1;
    while (!rdy(p) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({nm, " accept"}, {31'd0, rdy(p)}, 32'd1);
    @(posedge clk);
    #1;
    drive(p, 1'b0, 3'd2, 16'hA5A5, 16'h5A5A);
  endtask

  // Wait (bounded) for the response; check latency, enable duration and payload.
  task automatic wait_rsp(input bit p, input bit err, input logic [W-1:0] ed,
                          input logic [3:0] ef, input logic [W-1:0] ea,
                          input logic [2:0] eop, input string nm);
    int n = 0, en = 0;
    bit got = 0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (alu_enable) en++;
      if (rv(p)) got = 1;
    end
    chk({nm, " latency"}, n, err ? 32'd1 : SC + 1);
    chk({nm, " enable cycles"}, en, err ? 32'd0 : SC);
    chk({nm, " data"}, {16'd0, bus.rsp_data}, {16'd0, ed});
    chk({nm, " flags"}, {28'd0, bus.rsp_flags}, {28'd0, ef});
    chk({nm, " other rsp_valid"}, {31'd0, rv(~p)}, 32'd0);
    chk({nm, " tmp1 latched"}, {16'd0, alu_tmp1}, {16'd0, ea});
    chk({nm, " op latched"}, {29'd0, alu_op}, {29'd0, eop});
  endtask

  task automatic handshake(input bit p, input string nm);
    if (p) bus.rsp_ready1 = 1'b1; else bus.rsp_ready0 = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready0 = 1'b0;
    bus.rsp_ready1 = 1'b0;
    @(negedge clk);
    chk({nm, " rsp_valid drop"}, {31'd0, rv(p)}, 32'd0);
  endtask

  typedef struct {
    bit         port;
    logic [2:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit         err;
    logic [W-1:0] data;
    logic [3:0] flags;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d0;
    logic [3:0]   f0;
    bit           seen;
    bit           expg[4];

    vecs[0]  = '{0, 3'd0, 16'h7FFF, 16'h0001, 0, 16'h8000, 4'b0110};
    vecs[1]  = '{1, 3'd3, 16'h0064, 16'h0000, 1, 16'h0000, 4'b1001};
    vecs[2]  = '{0, 3'd1, 16'h0005, 16'h0003, 0, 16'h0002, 4'b0000};
    vecs[3]  = '{1, 3'd2, 16'h0004, 16'hFFFD, 0, 16'hFFF4, 4'b0100};
    vecs[4]  = '{0, 3'd4, 16'h0011, 16'h0005, 0, 16'h0002, 4'b0000};
    vecs[5]  = '{1, 3'd6, 16'h0001, 16'h0001, 1, 16'h0000, 4'b1001};
    vecs[6]  = '{0, 3'd4, 16'hFFF9, 16'h0002, 0, 16'hFFFF, 4'b0100};
    vecs[7]  = '{1, 3'd3, 16'hFF9C, 16'h0007, 0, 16'hFFF2, 4'b0100};
    vecs[8]  = '{0, 3'd0, 16'hFFFF, 16'h0001, 0, 16'h0000, 4'b0001};
    vecs[9]  = '{1, 3'd7, 16'h1234, 16'h0002, 1, 16'h0000, 4'b1001};
    vecs[10] = '{0, 3'd4, 16'h0005, 16'h0000, 1, 16'h0000, 4'b1001};
    vecs[11] = '{1, 3'd1, 16'h8000, 16'h0001, 0, 16'h7FFF, 4'b0010};
    vecs[12] = '{0, 3'd3, 16'h0000, 16'h0005, 0, 16'h0000, 4'b0001};

`ifdef ALU_SCHED_RR_EN
    expg = '{0, 1, 0, 1};
`else
    expg = '{0, 0, 0, 0};
`endif

    // Reset state, with a request pending so ready gating is exercised.
    reset_n = 1'b0;
    drive(0, 1'b1, 3'd0, 16'h0001, 16'h0001);
    drive(1, 1'b0, 3'd0, 16'h0000, 16'h0000);
    bus.rsp_ready0 = 1'b0;
    bus.rsp_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready0", {31'd0, bus.req_ready0}, 32'd0);
    chk("reset rsp_valid", {30'd0, bus.rsp_valid1, bus.rsp_valid0}, 32'd0);
    chk("reset rsp_data", {16'd0, bus.rsp_data}, 32'd0);
    chk("reset rsp_flags", {28'd0, bus.rsp_flags}, 32'd0);
    chk("reset alu_tmp", {alu_tmp1, alu_tmp2}, 32'd0);
    chk("reset alu_op/en", {28'd0, alu_op, alu_enable}, 32'd0);
    drive(0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    reset_n = 1'b1;

    // Table-driven single operations.
    for (int i = 0; i < 13; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      issue(vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, nm);
      wait_rsp(vecs[i].port, vecs[i].err, vecs[i].data, vecs[i].flags,
               vecs[i].a, vecs[i].op, nm);
      handshake(vecs[i].port, nm);
    end

    // Response back-pressure: everything holds, no new accepts, non-owner ready ignored.
    issue(0, 3'd2, 16'h0003, 16'h0005, "stall");
    wait_rsp(0, 0, 16'h000F, 4'b0000, 16'h0003, 3'd2, "stall");
    d0 = bus.rsp_data;
    f0 = bus.rsp_flags;
    drive(0, 1'b1, 3'd0, 16'h0001, 16'h0001);
    drive(1, 1'b1, 3'd0, 16'h0002, 16'h0002);
    bus.rsp_ready1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d rsp_valid0", k), {31'd0, bus.rsp_valid0}, 32'd1);
      chk($sformatf("stall%0d data", k), {16'd0, bus.rsp_data}, {16'd0, d0});
      chk($sformatf("stall%0d flags", k), {28'd0, bus.rsp_flags}, {28'd0, f0});
      chk($sformatf("stall%0d req_ready", k), {30'd0, bus.req_ready1, bus.req_ready0}, 32'd0);
    end
    bus.rsp_ready1 = 1'b0;
    drive(0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    bus.rsp_ready0 = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready0 = 1'b0;
    @(negedge clk);
    #1;
    chk("stall release rsp_valid0", {31'd0, bus.rsp_valid0}, 32'd0);
    chk("stall release req_ready1", {31'd0, bus.req_ready1}, 32'd1);
    drive(1, 1'b0, 3'd0, 16'h0000, 16'h0000);

    // Reset during SETTLE abandons the operation.
    issue(0, 3'd0, 16'h0001, 16'h0002, "abort");
    @(negedge clk);
    chk("abort in settle", {31'd0, alu_enable}, 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort alu_enable", {31'd0, alu_enable}, 32'd0);
    chk("abort rsp_valid", {30'd0, bus.rsp_valid1, bus.rsp_valid0}, 32'd0);
    chk("abort tmp1/data", {alu_tmp1, bus.rsp_data}, 32'd0);
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.rsp_valid0 || bus.rsp_valid1 || alu_enable) seen = 1;
    end
    chk("abort quiet after reset", {31'd0, seen}, 32'd0);
    issue(0, 3'd4, 16'h0011, 16'h0005, "post-abort mod");
    wait_rsp(0, 0, 16'h0002, 4'b0000, 16'h0011, 3'd4, "post-abort mod");
    handshake(0, "post-abort mod");

    // Contention: fresh reset so the pointer starts at port 0.
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.rsp_ready0 = 1'b1;
    bus.rsp_ready1 = 1'b1;
    drive(0, 1'b1, 3'd1, 16'h0005, 16'h0003);
    drive(1, 1'b1, 3'd2, 16'h0004, 16'hFFFD);
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      bit g;
      @(negedge clk);
      #1;
      while (!(bus.req_ready0 || bus.req_ready1) && n < 20) begin
        @(negedge clk); #1; n++;
      end
      g = bus.req_ready1;
      chk($sformatf("contend%0d grant", k), {31'd0, g}, {31'd0, expg[k]});
      chk($sformatf("contend%0d exclusive", k), {31'd0, bus.req_ready0 & bus.req_ready1}, 32'd0);
      @(posedge clk);
      n = 0;
      while (!rv(g) && n < 20) begin
        @(negedge clk); n++;
      end
      chk($sformatf("contend%0d data", k), {16'd0, bus.rsp_data},
          g ? 32'h0000FFF4 : 32'h00000002);
    end
    drive(0, 1'b0, 3'd0, 16'h0000, 16'h0000);
    drive(1, 1'b0, 3'd0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    bus.rsp_ready0 = 1'b0;
    bus.rsp_ready1 = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
